// File: rtl/mgt01_banked_reg_file.sv
// Banked register file with combinational read ports and a
// beat-serial context save/restore engine (valid/ready streams).
// Ports: clk_i/rst_i (sync, active-high); we_i/wr_addr_i/wr_data_i
//   write port; rd_addr_i/rd_data_o NUM_RD read ports;
//   ctx_save_i/ctx_restore_i start pulses; ctx_busy_o/ctx_done_o
//   status; ctx_addr_o beat index; ctx_valid_o/ctx_ready_i/ctx_data_o
//   save stream; ctx_valid_i/ctx_ready_o/ctx_data_i restore stream.
// Option: define MGT01_RF_BYPASS_EN for write-to-read forwarding.
module mgt01_banked_reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [AW-1:0]                  wr_addr_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr_i,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
  input  logic                           ctx_save_i,
  input  logic                           ctx_restore_i,
  output logic                           ctx_busy_o,
  output logic                           ctx_done_o,
  output logic [AW-1:0]                  ctx_addr_o,
  output logic                           ctx_valid_o,
  input  logic                           ctx_ready_i,
  output logic [DATA_W-1:0]              ctx_data_o,
  input  logic                           ctx_valid_i,
  output logic                           ctx_ready_o,
  input  logic [DATA_W-1:0]              ctx_data_i
);

  // Transfers skip the hardwired zero register.
  localparam logic [AW-1:0] FIRST =
    (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic wr_zero;
  logic wr_fire;
  logic save_beat;
  logic rest_beat;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr_i == '0);
  assign wr_fire = we_i && (state_q == ST_IDLE) && !wr_zero;
  assign save_beat = (state_q == ST_SAVE) && ctx_ready_i;
  assign rest_beat = (state_q == ST_RESTORE) && ctx_valid_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= FIRST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = FIRST;
        if (ctx_save_i) begin
          state_d = ST_SAVE;
        end else if (ctx_restore_i) begin
          state_d = ST_RESTORE;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        if (save_beat || rest_beat) begin
          if (idx_q == LAST) begin
            state_d = ST_DONE;
            idx_d   = FIRST;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ctx_busy_o  = 1'b0;
    ctx_done_o  = 1'b0;
    ctx_valid_o = 1'b0;
    ctx_ready_o = 1'b0;
    unique case (state_q)
      ST_SAVE: begin
        ctx_busy_o  = 1'b1;
        ctx_valid_o = 1'b1;
      end
      ST_RESTORE: begin
        ctx_busy_o  = 1'b1;
        ctx_ready_o = 1'b1;
      end
      ST_DONE: begin
        ctx_done_o = 1'b1;
      end
      default: begin
        ctx_busy_o = 1'b0;
      end
    endcase
  end

  assign ctx_addr_o = idx_q;
  assign ctx_data_o = regs_q[idx_q];

  // Register array; host writes and restore beats never
  // coincide because they need different FSM states.
  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[wr_addr_i] = wr_data_i;
    end
    if (rest_beat) begin
      regs_d[idx_q] = ctx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic rd_zero;
    assign rd_zero = (ZERO_REG != 0) && (rd_addr_i[k] == '0);

    always_comb begin
      if (rd_zero) begin
        rd_data_o[k] = '0;
`ifdef MGT01_RF_BYPASS_EN
      end else if (wr_fire && (wr_addr_i == rd_addr_i[k])) begin
        rd_data_o[k] = wr_data_i;
`endif
      end else begin
        rd_data_o[k] = regs_q[rd_addr_i[k]];
      end
    end
  end

endmodule

// File: tb/tb_mgt01_banked_reg_file.sv
// Self-checking bench for mgt01_banked_reg_file: random traffic
// against an array model, plus directed save/restore/reset scenarios.
module tb_mgt01_banked_reg_file;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, we, save, restore;
  logic                    rdy_i, vld_i;
  logic [AW-1:0]           wa;
  logic [DW-1:0]           wd, din;
  logic [NRD-1:0][AW-1:0]  ra;
  logic [NRD-1:0][DW-1:0]  rd;
  logic                    busy, done, vld_o, rdy_o;
  logic [AW-1:0]           caddr;
  logic [DW-1:0]           cdata;

  logic [DW-1:0] mdl [NR];
  int tests = 0;
  int fails = 0;

  mgt01_banked_reg_file dut (
    .clk_i(clk), .rst_i(rst),
    .we_i(we), .wr_addr_i(wa), .wr_data_i(wd),
    .rd_addr_i(ra), .rd_data_o(rd),
    .ctx_save_i(save), .ctx_restore_i(restore),
    .ctx_busy_o(busy), .ctx_done_o(done),
    .ctx_addr_o(caddr),
    .ctx_valid_o(vld_o), .ctx_ready_i(rdy_i),
    .ctx_data_o(cdata),
    .ctx_valid_i(vld_i), .ctx_ready_o(rdy_o),
    .ctx_data_i(din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mdl();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr_mdl();
    ra[0] = 5'd0;
    ra[1] = 5'd17;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || vld_o !== 1'b0 ||
        rdy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: got busy%b done%b vo%b ro%b want 0000",
               busy, done, vld_o, rdy_o);
    end
    tests++;
    if (caddr !== 5'd1 || cdata !== '0) begin
      fails++;
      $display("FAIL reset_ctx: got addr %0d data %h want 1 0",
               caddr, cdata);
    end
    tests++;
    if (rd[0] !== '0 || rd[1] !== '0) begin
      fails++;
      $display("FAIL reset_read: got %h %h want 0 0", rd[0], rd[1]);
    end
    tick();
    // reset beats a write and a start pulse in the same cycle
    we = 1'b1; wa = 5'd3; wd = 32'h1111_2222;
    tick();
    rst = 1'b1; wd = 32'h3333_4444; save = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; save = 1'b0;
    ra[0] = 5'd3;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rd[0] !== '0) begin
      fails++;
      $display("FAIL reset_prio: got busy %b r3 %h want 0 0",
               busy, rd[0]);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] expv;
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    mdl[5] = 32'hDEAD_BEEF;
    we = 1'b1; wa = 5'd0; wd = 32'h1;
    ra[0] = 5'd5; ra[1] = 5'd0;
    tick();
    we = 1'b0;
    @(negedge clk);
    tests++;
    if (rd[0] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL wr_r5: got %h want deadbeef", rd[0]);
    end
    tests++;
    if (rd[1] !== '0) begin
      fails++;
      $display("FAIL wr_r0: got %h want 0", rd[1]);
    end
    tick();
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom);
      wd = $urandom;
      for (int k = 0; k < NRD; k++) ra[k] = AW'($urandom);
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        expv = (ra[k] == 0) ? '0 : mdl[ra[k]];
`ifdef MGT01_RF_BYPASS_EN
        if (we && wa == ra[k] && ra[k] != 0) expv = wd;
`endif
        tests++;
        if (rd[k] !== expv) begin
          fails++;
          $display("FAIL rand_read p%0d a%0d: got %h want %h",
                   k, ra[k], rd[k], expv);
        end
      end
      if (we && wa != 0) mdl[wa] = wd;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_save_full();
    int exp_idx, beats, done_cyc;
    for (int i = 1; i < NR; i++) begin
      we = 1'b1; wa = AW'(i); wd = DW'(i * 32'h11);
      mdl[i] = wd;
      tick();
    end
    we = 1'b0;
    save = 1'b1;
    tick();
    save = 1'b0; rdy_i = 1'b1;
    exp_idx = 1; beats = 0; done_cyc = 0;
    // c counts edges after the one that sampled the pulse
    for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = c;
      end else if (vld_o) begin
        tests++;
        if (caddr !== AW'(exp_idx) ||
            cdata !== DW'(exp_idx * 32'h11)) begin
          fails++;
          $display("FAIL save_beat: got a%0d %h want a%0d %h",
                   caddr, cdata, exp_idx, exp_idx * 32'h11);
        end
        exp_idx++;
        beats++;
      end
      tick();
    end
    rdy_i = 1'b0;
    tests++;
    if (beats != 31) begin
      fails++;
      $display("FAIL save_count: got %0d want 31", beats);
    end
    // done in the 33rd cycle counting the pulse cycle itself
    tests++;
    if (done_cyc != 32) begin
      fails++;
      $display("FAIL save_latency: got %0d want 32", done_cyc);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL save_done_pulse: got done %b busy %b want 0 0",
               done, busy);
    end
    tick();
  endtask

  task automatic test_save_stall();
    int exp_idx, beats;
    bit got_done;
    save = 1'b1;
    tick();
    save = 1'b0;
    exp_idx = 1; beats = 0; got_done = 0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      rdy_i = (c % 2 == 1) && ($urandom_range(0, 3) != 0);
      we = (c == 7); wa = 5'd9; wd = $urandom;
      restore = (c == 4);
      @(negedge clk);
      if (done) begin
        got_done = 1;
      end else begin
        tests++;
        if (busy !== 1'b1 || vld_o !== 1'b1 || rdy_o !== 1'b0 ||
            caddr !== AW'(exp_idx) || cdata !== mdl[exp_idx]) begin
          fails++;
          $display("FAIL stall_beat: got b%b v%b r%b a%0d %h want 110 a%0d %h",
                   busy, vld_o, rdy_o, caddr, cdata,
                   exp_idx, mdl[exp_idx]);
        end
        if (rdy_i) begin
          exp_idx++;
          beats++;
        end
      end
      tick();
    end
    we = 1'b0; restore = 1'b0; rdy_i = 1'b0;
    tests++;
    if (beats != 31 || !got_done) begin
      fails++;
      $display("FAIL stall_count: got %0d done %0d want 31 1",
               beats, got_done);
    end
    ra[0] = 5'd9;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rdy_o !== 1'b0 || rd[0] !== mdl[9]) begin
      fails++;
      $display("FAIL stall_after: got b%b r%b r9 %h want 0 0 %h",
               busy, rdy_o, rd[0], mdl[9]);
    end
    tick();
  endtask

  task automatic test_restore();
    int exp_idx;
    bit got_done;
    logic [DW-1:0] expv;
    restore = 1'b1;
    tick();
    restore = 1'b0;
    exp_idx = 1; got_done = 0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      vld_i = ($urandom_range(0, 2) != 0);
      din = 32'hA000_0000 + DW'(exp_idx);
      ra[0] = AW'($urandom);
      ra[1] = AW'(exp_idx);
      @(negedge clk);
      if (done) begin
        got_done = 1;
      end else begin
        tests++;
        if (busy !== 1'b1 || rdy_o !== 1'b1 || vld_o !== 1'b0 ||
            caddr !== AW'(exp_idx)) begin
          fails++;
          $display("FAIL rest_hs: got b%b r%b v%b a%0d want 110 a%0d",
                   busy, rdy_o, vld_o, caddr, exp_idx);
        end
        expv = (ra[0] == 0) ? '0 : mdl[ra[0]];
        tests++;
        if (rd[0] !== expv || rd[1] !== mdl[exp_idx]) begin
          fails++;
          $display("FAIL rest_read: got %h %h want %h %h",
                   rd[0], rd[1], expv, mdl[exp_idx]);
        end
        if (vld_i) begin
          mdl[exp_idx] = din;
          exp_idx++;
        end
      end
      tick();
    end
    vld_i = 1'b0;
    tests++;
    if (exp_idx != 32 || !got_done) begin
      fails++;
      $display("FAIL rest_count: got %0d done %0d want 32 1",
               exp_idx, got_done);
    end
    for (int i = 0; i < NR; i++) begin
      ra[0] = AW'(i);
      #1;
      expv = (i == 0) ? '0 : 32'hA000_0000 + DW'(i);
      tests++;
      if (rd[0] !== expv) begin
        fails++;
        $display("FAIL rest_final r%0d: got %h want %h",
                 i, rd[0], expv);
      end
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int exp_idx, beats;
    bit got_done;
    restore = 1'b1;
    tick();
    restore = 1'b0;
    vld_i = 1'b1;
    exp_idx = 1;
    while (exp_idx < 10) begin
      din = 32'hB000_0000 + DW'(exp_idx);
      tick();
      exp_idx++;
    end
    rst = 1'b1; din = 32'hB000_000A;
    tick();
    rst = 1'b0; vld_i = 1'b0;
    clr_mdl();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rdy_o !== 1'b0 || caddr !== 5'd1) begin
      fails++;
      $display("FAIL abort_state: got b%b r%b a%0d want 0 0 1",
               busy, rdy_o, caddr);
    end
    for (int i = 0; i < NR; i++) begin
      ra[1] = AW'(i);
      #1;
      tests++;
      if (rd[1] !== '0) begin
        fails++;
        $display("FAIL abort_clear r%0d: got %h want 0", i, rd[1]);
      end
    end
    tick();
    save = 1'b1; restore = 1'b1;
    tick();
    save = 1'b0; restore = 1'b0; rdy_i = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || vld_o !== 1'b1 || rdy_o !== 1'b0) begin
      fails++;
      $display("FAIL both_start: got b%b v%b r%b want 1 1 0",
               busy, vld_o, rdy_o);
    end
    beats = 0; got_done = 0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        got_done = 1;
      end else if (vld_o) begin
        tests++;
        if (cdata !== '0) begin
          fails++;
          $display("FAIL both_data a%0d: got %h want 0", caddr, cdata);
        end
        beats++;
      end
      tick();
    end
    rdy_i = 1'b0;
    tests++;
    if (beats != 31 || !got_done) begin
      fails++;
      $display("FAIL both_count: got %0d done %0d want 31 1",
               beats, got_done);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] expv;
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    tick();
    mdl[7] = 32'h55;
    wd = 32'h1234; ra[0] = 5'd7;
    @(negedge clk);
`ifdef MGT01_RF_BYPASS_EN
    expv = 32'h1234;
`else
    expv = 32'h55;
`endif
    tests++;
    if (rd[0] !== expv) begin
      fails++;
      $display("FAIL byp_same: got %h want %h", rd[0], expv);
    end
    mdl[7] = 32'h1234;
    tick();
    we = 1'b0;
    @(negedge clk);
    tests++;
    if (rd[0] !== 32'h1234) begin
      fails++;
      $display("FAIL byp_next: got %h want 1234", rd[0]);
    end
    tick();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra[0] = 5'd0;
    @(negedge clk);
    tests++;
    if (rd[0] !== '0) begin
      fails++;
      $display("FAIL byp_zero: got %h want 0", rd[0]);
    end
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; save = 1'b0; restore = 1'b0;
    rdy_i = 1'b0; vld_i = 1'b0;
    wa = '0; wd = '0; din = '0; ra = '0;
    test_reset();
    test_write_read();
    test_save_full();
    test_save_stall();
    test_restore();
    test_reset_abort();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
